// File: rtl/iomemory_mmio.sv
// iomemory_mmio: data/fetch memory map with registered RAM, synchronised I/O bank and CPU-write/GPU-read VRAM.
// Latency: data read, fetch and GPU pixel are all registered, 1 cycle after the request.
// Backpressure: none; a new data, fetch and pixel request is accepted every cycle.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   we, rd_en, data_address,  data port: byte address decoded on [31:16]
//   data_input, data_output,  (0x0000 RAM, 0x0001 IO, 0x0002 VRAM, others unmapped)
//   rd_valid                  one-cycle pulse with read data
//   instr_address,            fetch port, RAM only, upper address bits ignored
//   instr_output
//   io_in                     NUM_IN asynchronous channels of IN_W bits
//   gpu_address, gpu_pixel    GPU pixel read port
//   bus_err                   error pulse, only with IOMEM_ERR_EN defined (tied 0 otherwise)
//
// Build option: define IOMEM_ERR_EN for bus_err reporting and the saturating error counter
// at IO word NUM_IN+1.

module iomemory_mmio #(
  parameter int DATA_W  = 32,
  parameter int RAM_AW  = 10,
  parameter int VRAM_AW = 16,
  parameter int NUM_IN  = 4,
  parameter int IN_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     rd_en,
  input  logic [31:0]              data_address,
  input  logic [DATA_W-1:0]        data_input,
  output logic [DATA_W-1:0]        data_output,
  output logic                     rd_valid,
  input  logic [31:0]              instr_address,
  output logic [DATA_W-1:0]        instr_output,
  input  logic [NUM_IN*IN_W-1:0]   io_in,
  input  logic [VRAM_AW-1:0]       gpu_address,
  output logic [7:0]               gpu_pixel,
  output logic                     bus_err
);

  localparam logic [15:0] REGION_RAM  = 16'h0000;
  localparam logic [15:0] REGION_IO   = 16'h0001;
  localparam logic [15:0] REGION_VRAM = 16'h0002;
  localparam logic [5:0]  WORD_EDGE   = 6'(NUM_IN);

  // ---------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------
  logic [15:0]        region;
  logic               is_ram;
  logic               is_io;
  logic               is_vram;
  logic [RAM_AW-1:0]  ram_idx;
  logic [RAM_AW-1:0]  fetch_idx;
  logic [VRAM_AW-1:0] vram_idx;
  logic [5:0]         io_word;
  logic               unused_addr_bits;

  assign region  = data_address[31:16];
  assign is_ram  = (region == REGION_RAM);
  assign is_io   = (region == REGION_IO);
  assign is_vram = (region == REGION_VRAM);

  // Word/pixel indices come only from the 64 KiB offset inside the region; bits that
  // would overlap the region selector read as zero, so large RAM/VRAM are only partly
  // reachable from the data port (the GPU port still sees all of VRAM).
  assign ram_idx   = RAM_AW'({16'h0000, data_address[15:2]});
  assign vram_idx  = VRAM_AW'({16'h0000, data_address[15:2]});
  assign io_word   = data_address[7:2];
  assign fetch_idx = instr_address[RAM_AW+1:2];

  assign unused_addr_bits = ^{data_address[1:0], instr_address};

  // ---------------------------------------------------------------
  // Storage arrays (contents survive reset)
  // ---------------------------------------------------------------
  logic [DATA_W-1:0] ram  [2**RAM_AW];
  logic [7:0]        vram [2**VRAM_AW];

  always_ff @(posedge clk) begin
    if (we && is_ram) begin
      ram[ram_idx] <= data_input;
    end
  end

  always_ff @(posedge clk) begin
    if (we && is_vram) begin
      vram[vram_idx] <= data_input[7:0];
    end
  end

  // ---------------------------------------------------------------
  // IO bank: 2-flop synchronisers and sticky rising-edge flags
  // ---------------------------------------------------------------
  logic [NUM_IN*IN_W-1:0] meta_q;
  logic [NUM_IN*IN_W-1:0] sync_q;
  logic [NUM_IN-1:0]      sync_bit0;
  logic [NUM_IN-1:0]      prev_bit0_q;
  logic [NUM_IN-1:0]      rise;
  logic [NUM_IN-1:0]      edge_q;
  logic                   edge_clr;

  always_comb begin
    sync_bit0 = '0;
    rise      = '0;
    for (int n = 0; n < NUM_IN; n++) begin
      sync_bit0[n] = sync_q[n*IN_W];
      rise[n]      = sync_q[n*IN_W] & ~prev_bit0_q[n];
    end
  end

  assign edge_clr = rd_en & is_io & (io_word == WORD_EDGE);

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q      <= '0;
      sync_q      <= '0;
      prev_bit0_q <= '0;
      edge_q      <= '0;
    end else begin
      meta_q      <= io_in;
      sync_q      <= meta_q;
      prev_bit0_q <= sync_bit0;
      // Clear-on-read is applied first so a rising edge in the same cycle survives.
      edge_q      <= (edge_q & ~{NUM_IN{edge_clr}}) | rise;
    end
  end

  // ---------------------------------------------------------------
  // Optional error reporting
  // ---------------------------------------------------------------
`ifdef IOMEM_ERR_EN
  localparam logic [5:0] WORD_ERR = 6'(NUM_IN + 1);

  logic        is_unmapped;
  logic        err_ev;
  logic        cnt_clr;
  logic [15:0] cnt_base;
  logic [15:0] err_cnt_q;
  logic        bus_err_q;

  assign is_unmapped = ~(is_ram | is_io | is_vram);
  assign err_ev      = (we | rd_en) & (is_unmapped | (we & is_io) | (rd_en & is_vram));
  assign cnt_clr     = rd_en & is_io & (io_word == WORD_ERR);
  assign cnt_base    = cnt_clr ? 16'h0000 : err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= err_ev;
      if (err_ev && (cnt_base != 16'hFFFF)) begin
        err_cnt_q <= cnt_base + 16'h0001;
      end else begin
        err_cnt_q <= cnt_base;
      end
    end
  end

  // Masked by rst so a pulse belonging to a discarded access never appears.
  assign bus_err = bus_err_q & ~rst;
`else
  assign bus_err = 1'b0;
`endif

  // ---------------------------------------------------------------
  // Data read mux: evaluated in the request cycle, so every source is read-first
  // and clear-on-read registers return their pre-clear value.
  // ---------------------------------------------------------------
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (is_ram) begin
      rd_data = ram[ram_idx];
    end else if (is_io) begin
      for (int n = 0; n < NUM_IN; n++) begin
        if (io_word == 6'(n)) begin
          rd_data = DATA_W'(sync_q[n*IN_W +: IN_W]);
        end
      end
      if (io_word == WORD_EDGE) begin
        rd_data = DATA_W'(edge_q);
      end
`ifdef IOMEM_ERR_EN
      if (io_word == WORD_ERR) begin
        rd_data = DATA_W'(err_cnt_q);
      end
`endif
    end
    // VRAM and unmapped regions read as zero.
  end

  // ---------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------
  logic rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q   <= 1'b0;
      data_output  <= '0;
      instr_output <= '0;
      gpu_pixel    <= '0;
    end else begin
      rd_valid_q   <= rd_en;
      if (rd_en) begin
        data_output <= rd_data;
      end
      instr_output <= ram[fetch_idx];
      gpu_pixel    <= vram[gpu_address];
    end
  end

  // A read issued just before reset is dropped as soon as rst is seen.
  assign rd_valid = rd_valid_q & ~rst;

endmodule
